// File: rtl/fos_inverse_seq_pkg.sv
// Shared filter package: FSM states, multiplier iteration count, default
// fixed-point format and the radix-4 Booth partial-product helper.
package fos_inverse_seq_pkg;

   localparam int FRAC_DEFAULT = 16;  // Q16.16 data and coefficients
   localparam int MUL_ITER     = 16;  // radix-4 digits in a 32-bit operand

   typedef enum logic [2:0] {
      IDLE,
      MUL_A,
      MUL_B,
      SUM,
      OUT
   } state_t;

   // One Booth digit applied to the (already weighted) multiplicand.
   // trip = {b[2j+1], b[2j], b[2j-1]} selects 0, +-1 or +-2 times mcand.
   function automatic logic [63:0] booth_pp(input logic [2:0] trip,
                                            input logic [63:0] mcand);
      logic [63:0] pp;
      case (trip)
         3'b001, 3'b010: pp = mcand;
         3'b011:         pp = mcand << 1;
         3'b100:         pp = -(mcand << 1);
         3'b101, 3'b110: pp = -mcand;
         default:        pp = '0;
      endcase
      return pp;
   endfunction

endpackage

// File: rtl/fos_inverse_seq_if.sv
// Stream interface of the inverse section: y samples with their
// coefficients in, reconstructed u samples out, valid/ready on both sides.
interface fos_inverse_seq_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [31:0] a1;
   logic [31:0] b1;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   // Producer of y samples and consumer of u samples.
   modport master (
      output in_valid, in_data, a1, b1, out_ready,
      input  in_ready, out_valid, out_data
   );

   // The filter block itself.
   modport slave (
      input  in_valid, in_data, a1, b1, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/fos_inverse_seq_rad4_seq_mult.sv
// Sequential 32x32 signed multiplier, radix-4 Booth, one partial product
// per cycle. Digit 0 is folded into the start cycle, so with start sampled
// at edge t the product is complete after edge t+15 and done pulses for the
// cycle that follows.
module rad4_seq_mult
   import fos_inverse_seq_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        done,
   output logic [63:0] p
);

   logic [63:0] r_acc;
   logic [63:0] r_mcand;   // multiplicand pre-weighted by 4^j
   logic [32:0] r_bx;      // multiplier with b[-1] appended, shifted 2/cycle
   logic [4:0]  r_cnt;     // digits still to accumulate
   logic        r_busy;
   logic        r_done;

   logic [63:0] w_mcand0;
   logic [63:0] w_pp0;
   logic [63:0] w_pp;

   assign w_mcand0 = {{32{a[31]}}, a};
   assign w_pp0    = booth_pp({b[1:0], 1'b0}, w_mcand0);
   assign w_pp     = booth_pp(r_bx[2:0], r_mcand);

   // Load and first digit on start, then accumulate the remaining digits.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         r_acc   <= '0;
         r_mcand <= '0;
         r_bx    <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (start) begin
         r_acc   <= w_pp0;
         r_mcand <= w_mcand0 << 2;
         r_bx    <= {b[31], b[31], b[31:1]};
         r_cnt   <= 5'(MUL_ITER - 1);
         r_busy  <= 1'b1;
         r_done  <= 1'b0;
      end else if (r_busy) begin
         r_acc   <= r_acc + w_pp;
         r_mcand <= r_mcand << 2;
         r_bx    <= {r_bx[32], r_bx[32], r_bx[32:2]};
         r_cnt   <= r_cnt - 5'd1;
         r_busy  <= (r_cnt != 5'd1);
         r_done  <= (r_cnt == 5'd1);
      end else begin
         r_done  <= 1'b0;
      end
   end

   assign done = r_done;
   assign p    = r_acc;

endmodule

// File: rtl/fos_inverse_seq.sv
// Inverse first-order section: u[n] = y[n] + a1*y[n-1] - b1*u[n-1].
// Both products share one sequential multiplier; a1*y_prev is launched on
// the accepting edge, b1*u_prev one cycle after the first product lands.
module fos_inverse_seq
   import fos_inverse_seq_pkg::*;
#(
   parameter int FRAC = FRAC_DEFAULT
)
(
   input  logic            clk,
   input  logic            reset,
   fos_inverse_seq_if.slave bus
);

   state_t r_state;
   state_t w_next;

   logic [31:0] r_y;         // sample in flight
   logic [31:0] r_b1;        // b1 captured with the sample
   logic [31:0] r_y_prev;
   logic [31:0] r_u_prev;
   logic [31:0] r_pa;
   logic [31:0] r_pb;
   logic [31:0] r_out_data;
   logic        r_mul_b_go;  // launches the second product

   logic               w_accept;
   logic               w_mul_start;
   logic [31:0]        w_mul_a;
   logic [31:0]        w_mul_b;
   logic               w_mul_done;
   logic [63:0]        w_mul_p;
   logic signed [63:0] w_mul_ps;
   logic [31:0]        w_prod;
   logic [31:0]        w_sum;

   assign w_accept    = bus.in_valid && (r_state == IDLE);
   assign w_mul_start = w_accept || r_mul_b_go;
   // a1 is only needed at the accepting edge, so it feeds the multiplier directly.
   assign w_mul_a     = w_accept ? bus.a1   : r_b1;
   assign w_mul_b     = w_accept ? r_y_prev : r_u_prev;

   rad4_seq_mult u_mult (
      .clk   (clk),
      .reset (reset),
      .start (w_mul_start),
      .a     (w_mul_a),
      .b     (w_mul_b),
      .done  (w_mul_done),
      .p     (w_mul_p)
   );

   // Floor scaling back to the data format, keeping the low 32 bits.
   assign w_mul_ps = $signed(w_mul_p);
   assign w_prod   = 32'(w_mul_ps >>> FRAC);
   assign w_sum    = r_y + r_pa - r_pb;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default first so no path leaves w_next unassigned (no latch).
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.in_valid)  w_next = MUL_A;
         MUL_A:   if (w_mul_done)    w_next = MUL_B;
         MUL_B:   if (w_mul_done)    w_next = SUM;
         SUM:                        w_next = OUT;
         OUT:     if (bus.out_ready) w_next = IDLE;
         default:                    w_next = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      bus.in_ready  = (r_state == IDLE);
      bus.out_valid = (r_state == OUT);
   end

   // Sample capture, product latches and history update.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_y        <= '0;
         r_b1       <= '0;
         r_y_prev   <= '0;
         r_u_prev   <= '0;
         r_pa       <= '0;
         r_pb       <= '0;
         r_out_data <= '0;
         r_mul_b_go <= 1'b0;
      end else begin
         r_mul_b_go <= (r_state == MUL_A) && w_mul_done;
         if (w_accept) begin
            r_y  <= bus.in_data;
            r_b1 <= bus.b1;
         end
         if ((r_state == MUL_A) && w_mul_done) r_pa <= w_prod;
         if ((r_state == MUL_B) && w_mul_done) r_pb <= w_prod;
         if (r_state == SUM) begin
            r_out_data <= w_sum;
            r_y_prev   <= r_y;
            r_u_prev   <= w_sum;
         end
      end
   end

   assign bus.out_data = r_out_data;

endmodule

// File: tb/tb_fos_inverse_seq.sv
// Self-checking bench for fos_inverse_seq: directed cases, backpressure,
// mid-operation reset and a randomized stream against an arithmetic model.
module tb_fos_inverse_seq;
   import fos_inverse_seq_pkg::*;

   localparam int LAT = 34;  // accept edge to first out_valid edge

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;

   logic [31:0] m_y_prev;
   logic [31:0] m_u_prev;
   logic [31:0] u;

   fos_inverse_seq_if bus ();

   fos_inverse_seq #(.FRAC(FRAC_DEFAULT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // floor(c*d / 2^FRAC) modulo 2^32
   function automatic logic [31:0] scale(input logic [31:0] c, input logic [31:0] d);
      longint prod;
      prod = longint'($signed(c)) * longint'($signed(d));
      prod = prod >>> FRAC_DEFAULT;
      return 32'(prod);
   endfunction

   function automatic logic [31:0] model_step(input logic [31:0] y, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [31:0] un;
      un = y + scale(a, m_y_prev) - scale(b, m_u_prev);
      m_y_prev = y;
      m_u_prev = un;
      return un;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      m_y_prev = '0;
      m_u_prev = '0;
   endtask

   // One sample through the block; stall = cycles of held-off out_ready.
   task automatic send(input string tag, input logic [31:0] y, input logic [31:0] a,
                       input logic [31:0] b, input int stall, output logic [31:0] u_obs);
      logic [31:0] exp_u;
      logic [31:0] held;
      int k;
      int rdy_hi;
      int bad;
      exp_u = model_step(y, a, b);
      u_obs = 'x;
      check({tag, " idle in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid  = 1'b1;
      bus.in_data   = y;
      bus.a1        = a;
      bus.b1        = b;
      bus.out_ready = (stall == 0);
      @(posedge clk); #1;
      // Scramble the inputs: nothing may be re-sampled while busy.
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
      bus.a1       = $urandom;
      bus.b1       = $urandom;
      k = 0;
      rdy_hi = 0;
      while (!bus.out_valid && k < 60) begin
         if (bus.in_ready) rdy_hi++;
         @(posedge clk); #1;
         k++;
      end
      if (!bus.out_valid) begin
         check({tag, " timeout out_valid"}, 32'(bus.out_valid), 32'd1);
         do_reset();
         return;
      end
      check({tag, " latency"}, 32'(k), 32'(LAT));
      check({tag, " busy in_ready"}, 32'(rdy_hi), 32'd0);
      u_obs = bus.out_data;
      check({tag, " u"}, bus.out_data, exp_u);
      if (stall > 0) begin
         held = bus.out_data;
         bad = 0;
         bus.in_valid = 1'b1;
         bus.in_data  = $urandom;
         repeat (stall) begin
            @(posedge clk); #1;
            if (bus.out_data !== held || !bus.out_valid || bus.in_ready) bad++;
         end
         check({tag, " stall hold"}, 32'(bad), 32'd0);
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      check({tag, " post out_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, " post in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.a1        = '0;
      bus.b1        = '0;
      bus.out_ready = 1'b0;
      m_y_prev      = '0;
      m_u_prev      = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("reset in_ready",  32'(bus.in_ready),  32'd1);
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset out_data",  bus.out_data,       32'd0);

      // Pass-through
      send("pass0", 32'h0005_0000, 32'h0, 32'h0, 0, u);
      check("pass0 value", u, 32'h0005_0000);
      send("pass1", 32'h0007_0000, 32'h0, 32'h0, 0, u);
      check("pass1 value", u, 32'h0007_0000);

      // Matched inverse of a 0.5 / 0.25 section
      do_reset();
      send("inv0", 32'h0000_0000, 32'h0000_8000, 32'h0000_4000, 0, u);
      check("inv0 value", u, 32'h0000_0000);
      send("inv1", 32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 0, u);
      check("inv1 value", u, 32'h0001_0000);
      send("inv2", 32'hFFFF_C000, 32'h0000_8000, 32'h0000_4000, 0, u);
      check("inv2 value", u, 32'h0000_0000);
      send("inv3", 32'h0000_2000, 32'h0000_8000, 32'h0000_4000, 0, u);
      check("inv3 value", u, 32'h0000_0000);

      // Floor rounding of a negative product
      do_reset();
      send("floor0", 32'h0000_0001, 32'hFFFF_8000, 32'h0, 0, u);
      check("floor0 value", u, 32'h0000_0001);
      send("floor1", 32'h0000_0000, 32'hFFFF_8000, 32'h0, 0, u);
      check("floor1 value", u, 32'hFFFF_FFFF);

      // Backpressure with a pending input
      send("bp", 32'h1234_5678, 32'h0001_8000, 32'hFFFF_2000, 10, u);

      // Reset while the second product is being computed
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0042_0000;
      bus.a1       = 32'h0003_0000;
      bus.b1       = 32'h0002_0000;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      m_y_prev = '0;
      m_u_prev = '0;
      check("midrst out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst out_data",  bus.out_data,       32'd0);
      check("midrst in_ready",  32'(bus.in_ready),  32'd1);
      send("midrst next", 32'h0003_0000, 32'h0001_0000, 32'h0001_0000, 0, u);
      check("midrst next value", u, 32'h0003_0000);

      // Randomized stream; small coefficients keep the recursion interesting
      for (int i = 0; i < 24; i++) begin
         logic [31:0] ry, ra, rb;
         ry = $urandom;
         ra = (i % 3 == 0) ? 32'($urandom) : 32'($signed(18'($urandom)));
         rb = (i % 3 == 0) ? 32'($urandom) : 32'($signed(18'($urandom)));
         send($sformatf("rand%0d", i), ry, ra, rb, int'($urandom_range(0, 3)), u);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
